// File: rtl/multicycle_controller.sv
// Multicycle processor controller: one FSM steps through fetch, decode,
// execute, memory and writeback, with memory handshake, halt and trap.
module multicycle_controller #(
    parameter int OP_W      = 3,
    parameter int FUNCT_W   = 3,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 iord,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 halted,
    output logic                 illegal,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIWB = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_HALT   = 4'd11,
        S_FAULT  = 4'd12
    } state_t;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_J    = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0000);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0001);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0010);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0110);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4'b0111);
    localparam logic [ALUCTRL_W-1:0] ALU_NOR = ALUCTRL_W'(4'b1100);

    state_t     state_q, state_d;
    logic       pcwrite, branch;
    logic       op_ok, fn_ok;
    logic [2:0] opc, fn;

    // Only the low 3 bits are decoded; any upper bit set is illegal.
    assign op_ok = ((op >> 3) == '0);
    assign fn_ok = ((funct >> 3) == '0);
    assign opc   = op[2:0];
    assign fn    = funct[2:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b10;
                if (!op_ok) state_d = S_FAULT;
                else begin
                    case (opc)
                        OP_R, OP_ADDI: state_d = S_EXEC;
                        OP_LW, OP_SW:  state_d = S_MEMADR;
                        OP_BEQ:        state_d = S_BRANCH;
                        OP_J:          state_d = S_JUMP;
                        OP_HALT:       state_d = S_HALT;
                        default:       state_d = S_FAULT;
                    endcase
                end
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op_ok && opc == OP_LW)      state_d = S_MEMRD;
                else if (op_ok && opc == OP_SW) state_d = S_MEMWR;
                else                            state_d = S_FAULT;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                if (op_ok && opc == OP_R) begin
                    alusrcb = 2'b00;
                    state_d = S_ALUWB;
                    if (!fn_ok) state_d = S_FAULT;
                    else begin
                        case (fn)
                            3'd0:    alucontrol = ALU_ADD;
                            3'd1:    alucontrol = ALU_SUB;
                            3'd2:    alucontrol = ALU_AND;
                            3'd3:    alucontrol = ALU_OR;
                            3'd4:    alucontrol = ALU_SLT;
                            3'd5:    alucontrol = ALU_NOR;
                            default: state_d    = S_FAULT;
                        endcase
                    end
                end else if (op_ok && opc == OP_ADDI) begin
                    alusrcb = 2'b10;
                    state_d = S_ADDIWB;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  halted  = 1'b1;
            S_FAULT: illegal = 1'b1;
            default: state_d = S_FAULT;
        endcase

        pc_en = pcwrite | (branch & zero);

        // Reset forces a quiet fetch request regardless of mem_ready.
        if (!reset_n) begin
            pc_en      = 1'b0;
            iord       = 1'b0;
            memread    = 1'b1;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b01;
            pcsrc      = 2'b00;
            alucontrol = '0;
            halted     = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class,
// memory stalls, traps, halt and asynchronous reset.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] op;
    logic [2:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, memread, memwrite, irwrite;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol;
    logic       halted, illegal;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_controller #(
        .OP_W(3), .FUNCT_W(3), .ALUCTRL_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_en(pc_en),
        .iord(iord), .memread(memread), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .halted(halted),
        .illegal(illegal), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n   = 1'b0;
        op        = 3'd0;
        funct     = 3'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #12;
        chk("rst_state", state, 0);
        chk("rst_memread", memread, 1);
        chk("rst_alusrcb", alusrcb, 1);
        chk("rst_aluctl", alucontrol, 0);
        chk("rst_irwrite", irwrite, 0);
        chk("rst_pc_en", pc_en, 0);

        // RTYPE add
        reset_n = 1'b1;
        #1;
        chk("f_irwrite", irwrite, 1);
        chk("f_pc_en", pc_en, 1);
        chk("f_aluctl", alucontrol, 4'b0010);
        tick();
        chk("r_s1", state, 1);
        chk("r_dec_srcb", alusrcb, 2'b10);
        tick();
        chk("r_s6", state, 6);
        chk("r_exec_ctl", alucontrol, 4'b0010);
        chk("r_exec_srca", alusrca, 1);
        chk("r_exec_rw", regwrite, 0);
        tick();
        chk("r_s7", state, 7);
        chk("r_wb_rw", regwrite, 1);
        chk("r_wb_dst", regdst, 1);
        tick();
        chk("r_s0", state, 0);
        chk("r_end_rw", regwrite, 0);

        // FETCH stall
        mem_ready = 1'b0;
        #1;
        chk("fs_irwrite", irwrite, 0);
        chk("fs_pc_en", pc_en, 0);
        tick();
        chk("fs_state", state, 0);

        // LW with two wait cycles in MEMRD
        mem_ready = 1'b1;
        op = 3'd2;
        tick();
        chk("lw_s1", state, 1);
        tick();
        chk("lw_s2", state, 2);
        tick();
        chk("lw_s3a", state, 3);
        mem_ready = 1'b0;
        #1;
        chk("lw_rd_a", {memread, iord}, 2'b11);
        tick();
        chk("lw_s3b", state, 3);
        chk("lw_rd_b", {memread, iord}, 2'b11);
        tick();
        chk("lw_s3c", state, 3);
        chk("lw_rd_c", {memread, iord}, 2'b11);
        chk("lw_nowb", regwrite, 0);
        mem_ready = 1'b1;
        tick();
        chk("lw_s4", state, 4);
        chk("lw_wb", {memtoreg, regwrite, regdst}, 3'b110);
        tick();
        chk("lw_s0", state, 0);
        chk("lw_wb_off", {memtoreg, regwrite}, 2'b00);

        // ADDI
        op = 3'd1;
        tick();
        tick();
        chk("ad_s6", state, 6);
        chk("ad_srcb", alusrcb, 2'b10);
        tick();
        chk("ad_s8", state, 8);
        chk("ad_wb", {regwrite, regdst}, 2'b10);
        tick();
        chk("ad_s0", state, 0);

        // BEQ taken then not taken
        op = 3'd4;
        zero = 1'b1;
        tick();
        tick();
        chk("bt_s9", state, 9);
        chk("bt_pc_en", pc_en, 1);
        chk("bt_pcsrc", pcsrc, 2'b01);
        chk("bt_ctl", alucontrol, 4'b0110);
        tick();
        chk("bt_s0", state, 0);
        zero = 1'b0;
        tick();
        tick();
        chk("bn_s9", state, 9);
        chk("bn_pc_en", pc_en, 0);
        tick();
        chk("bn_s0", state, 0);

        // J
        op = 3'd5;
        tick();
        tick();
        chk("j_s10", state, 10);
        chk("j_pc", {pc_en, pcsrc}, 3'b110);
        tick();
        chk("j_s0", state, 0);

        // SW, reset while stalled in MEMWR
        op = 3'd3;
        tick();
        tick();
        tick();
        chk("sw_s5", state, 5);
        chk("sw_wr", {memwrite, iord}, 2'b11);
        mem_ready = 1'b0;
        tick();
        chk("sw_hold", state, 5);
        reset_n = 1'b0;
        #1;
        chk("sw_rst_wr", memwrite, 0);
        chk("sw_rst_st", state, 0);
        chk("sw_rst_rd", memread, 1);
        tick();
        reset_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("sw_rel_st", state, 0);
        chk("sw_rel_rd", memread, 1);

        // Illegal opcode
        op = 3'd7;
        tick();
        tick();
        chk("il_s12", state, 12);
        for (int i = 0; i < 20; i++) begin
            chk("il_hold", {state, illegal, regwrite, memwrite},
                {4'd12, 3'b100});
            tick();
        end
        reset_n = 1'b0;
        #1;
        chk("il_rst", state, 0);
        chk("il_rst_ill", illegal, 0);

        // Illegal RTYPE funct
        op = 3'd0;
        funct = 3'd6;
        reset_n = 1'b1;
        tick();
        tick();
        chk("fn_s6", state, 6);
        tick();
        chk("fn_s12", state, 12);
        chk("fn_ill", {illegal, regwrite}, 2'b10);

        // HALT
        reset_n = 1'b0;
        #1;
        op = 3'd6;
        funct = 3'd0;
        reset_n = 1'b1;
        tick();
        chk("h_s1", {state, halted}, {4'd1, 1'b0});
        tick();
        chk("h_s11", {state, halted}, {4'd11, 1'b1});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("h_hold", {state, halted, memread}, {4'd11, 2'b10});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
